// File: rtl/cluster_core_data_demux_pkg.sv
// pulp_cluster_package: shared owner encoding and default TCDM decode for the core data demux.
package pulp_cluster_package;
  typedef enum logic [1:0] {DMX_IDLE, DMX_TCDM, DMX_PERIPH} demux_owner_e;
  localparam logic [31:0] DEF_TCDM_BASE = 32'h1000_0000;
  localparam int DEF_TCDM_MASK_LSB = 20;
endpackage

// File: rtl/cluster_core_data_demux_cnt.sv
// demux_outstanding_cnt: outstanding-transaction counter with full/empty flags and saturation checks.
module demux_outstanding_cnt #(
  parameter int MAX = 4,
  parameter int CNT_W = $clog2(MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             full,
  output logic             empty
);
  assign cnt_nxt = inc == dec ? cnt : inc ? cnt + 1'b1 : cnt - 1'b1;
  assign full = cnt == CNT_W'(MAX);
  assign empty = cnt == '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt <= '0;
    else cnt <= cnt_nxt;
  end
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(inc && !dec && full)) else $error("outstanding counter overflow");
      assert (!(dec && !inc && empty)) else $error("outstanding counter underflow");
    end
  end
endmodule

// File: rtl/cluster_core_data_demux.sv
// cluster_core_data_demux: steers core data accesses to TCDM or periph, keeping responses in order.
// Optional CLUSTER_ALIAS_EN also decodes the cluster alias region as TCDM.
module cluster_core_data_demux
  import pulp_cluster_package::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] TCDM_BASE = DEF_TCDM_BASE,
  parameter int TCDM_MASK_LSB = DEF_TCDM_MASK_LSB,
  parameter logic [ADDR_WIDTH-1:0] CLUSTER_ALIAS_BASE = 32'h0000_0000,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_add_i,
  input  logic                  data_wen_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  input  logic [BE_WIDTH-1:0]   data_be_i,
  output logic                  data_gnt_o,
  output logic                  data_r_valid_o,
  output logic [DATA_WIDTH-1:0] data_r_rdata_o,
  output logic                  data_r_opc_o,
  output logic                  tcdm_req_o,
  output logic [ADDR_WIDTH-1:0] tcdm_add_o,
  output logic                  tcdm_wen_o,
  output logic [DATA_WIDTH-1:0] tcdm_data_o,
  output logic [BE_WIDTH-1:0]   tcdm_be_o,
  input  logic                  tcdm_gnt_i,
  input  logic                  tcdm_r_valid_i,
  input  logic [DATA_WIDTH-1:0] tcdm_r_data_i,
  output logic                  periph_req_o,
  output logic [ADDR_WIDTH-1:0] periph_add_o,
  output logic                  periph_wen_o,
  output logic [DATA_WIDTH-1:0] periph_wdata_o,
  output logic [BE_WIDTH-1:0]   periph_be_o,
  input  logic                  periph_gnt_i,
  input  logic                  periph_r_valid_i,
  input  logic [DATA_WIDTH-1:0] periph_r_rdata_i,
  input  logic                  periph_r_opc_i,
  output logic                  spurious_rsp_o
);
  demux_owner_e owner, owner_nxt, target;
  logic is_tcdm, fwd_req, own_rsp, rsp, stray, full, empty;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ADDR_WIDTH-TCDM_MASK_LSB-1:0] region;
  assign region = data_add_i[ADDR_WIDTH-1:TCDM_MASK_LSB];
`ifdef CLUSTER_ALIAS_EN
  assign is_tcdm = region == TCDM_BASE[ADDR_WIDTH-1:TCDM_MASK_LSB] ||
                   region == CLUSTER_ALIAS_BASE[ADDR_WIDTH-1:TCDM_MASK_LSB];
`else
  logic unused_alias;
  assign unused_alias = ^CLUSTER_ALIAS_BASE;
  assign is_tcdm = region == TCDM_BASE[ADDR_WIDTH-1:TCDM_MASK_LSB];
`endif
  assign {tcdm_add_o, tcdm_wen_o, tcdm_data_o, tcdm_be_o} = {data_add_i, data_wen_i, data_wdata_i, data_be_i};
  assign {periph_add_o, periph_wen_o, periph_wdata_o, periph_be_o} = {data_add_i, data_wen_i, data_wdata_i, data_be_i};
  // A different target may only be entered once the current owner has fully drained.
  always_comb begin
    target = is_tcdm ? DMX_TCDM : DMX_PERIPH;
    fwd_req = data_req_i && (owner == DMX_IDLE || (owner == target && !full));
    tcdm_req_o = fwd_req && is_tcdm;
    periph_req_o = fwd_req && !is_tcdm;
    data_gnt_o = fwd_req && (is_tcdm ? tcdm_gnt_i : periph_gnt_i);
    own_rsp = owner == DMX_TCDM ? tcdm_r_valid_i : owner == DMX_PERIPH ? periph_r_valid_i : 1'b0;
    rsp = own_rsp && !empty;
    stray = (tcdm_r_valid_i && owner != DMX_TCDM) || (periph_r_valid_i && owner != DMX_PERIPH) ||
            (own_rsp && empty);
    data_r_valid_o = rsp;
    data_r_rdata_o = owner == DMX_PERIPH ? periph_r_rdata_i : tcdm_r_data_i;
    data_r_opc_o = owner == DMX_PERIPH && periph_r_opc_i;
    owner_nxt = data_gnt_o ? target : cnt_nxt == '0 ? DMX_IDLE : owner;
  end
  demux_outstanding_cnt #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .inc    (data_gnt_o),
    .dec    (rsp),
    .cnt    (cnt),
    .cnt_nxt(cnt_nxt),
    .full   (full),
    .empty  (empty)
  );
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner <= DMX_IDLE;
      spurious_rsp_o <= 1'b0;
    end else begin
      owner <= owner_nxt;
      spurious_rsp_o <= spurious_rsp_o || stray;
    end
  end
endmodule

// File: tb/tb_cluster_core_data_demux.sv
// tb_cluster_core_data_demux: directed vector table for decode/gating plus hand-written ordering sequences.
module tb_cluster_core_data_demux;
  logic clk_i = 1'b0, rst_ni = 1'b0;
  logic data_req_i = 1'b0, data_wen_i = 1'b1;
  logic [31:0] data_add_i = '0, data_wdata_i = 32'hA5A5_0001;
  logic [3:0] data_be_i = 4'hF;
  logic data_gnt_o, data_r_valid_o, data_r_opc_o;
  logic [31:0] data_r_rdata_o;
  logic tcdm_req_o, tcdm_wen_o, periph_req_o, periph_wen_o;
  logic [31:0] tcdm_add_o, tcdm_data_o, periph_add_o, periph_wdata_o;
  logic [3:0] tcdm_be_o, periph_be_o;
  logic tcdm_gnt_i = 1'b0, tcdm_r_valid_i = 1'b0, periph_gnt_i = 1'b0, periph_r_valid_i = 1'b0;
  logic periph_r_opc_i = 1'b0;
  logic [31:0] tcdm_r_data_i = 32'hDEAD_BEEF, periph_r_rdata_i = 32'h1234_5678;
  logic spurious_rsp_o;
  int total = 0, bad = 0;

  always #5 clk_i = ~clk_i;

  cluster_core_data_demux dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i), .data_gnt_o(data_gnt_o),
    .data_r_valid_o(data_r_valid_o), .data_r_rdata_o(data_r_rdata_o), .data_r_opc_o(data_r_opc_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_add_o(tcdm_add_o), .tcdm_wen_o(tcdm_wen_o),
    .tcdm_data_o(tcdm_data_o), .tcdm_be_o(tcdm_be_o), .tcdm_gnt_i(tcdm_gnt_i),
    .tcdm_r_valid_i(tcdm_r_valid_i), .tcdm_r_data_i(tcdm_r_data_i),
    .periph_req_o(periph_req_o), .periph_add_o(periph_add_o), .periph_wen_o(periph_wen_o),
    .periph_wdata_o(periph_wdata_o), .periph_be_o(periph_be_o), .periph_gnt_i(periph_gnt_i),
    .periph_r_valid_i(periph_r_valid_i), .periph_r_rdata_i(periph_r_rdata_i),
    .periph_r_opc_i(periph_r_opc_i), .spurious_rsp_o(spurious_rsp_o)
  );

  typedef struct {
    logic req;
    logic [31:0] add;
    logic tg, pg;
    logic treq, preq, gnt;
  } vec_t;
  vec_t v[8];

  localparam logic [31:0] TA = 32'h1000_0040, PA = 32'h1020_0000;
`ifdef CLUSTER_ALIAS_EN
  localparam logic ALIAS_TCDM = 1'b1;
`else
  localparam logic ALIAS_TCDM = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    v[0] = '{1'b1, TA,            1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    v[1] = '{1'b1, TA,            1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    v[2] = '{1'b1, PA,            1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    v[3] = '{1'b1, PA,            1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    v[4] = '{1'b0, 32'h1000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    v[5] = '{1'b1, 32'h100F_FFFC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    v[6] = '{1'b1, 32'h0000_0100, 1'b1, 1'b1, ALIAS_TCDM, !ALIAS_TCDM, 1'b1};
    v[7] = '{1'b1, 32'h2000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    tick();
    chk("rst_tcdm_req", 32'(tcdm_req_o), 0);
    chk("rst_periph_req", 32'(periph_req_o), 0);
    chk("rst_gnt", 32'(data_gnt_o), 0);
    chk("rst_rvalid", 32'(data_r_valid_o), 0);
    chk("rst_spurious", 32'(spurious_rsp_o), 0);
    rst_ni = 1'b1;
    tick();

    // Idle-state decode and gating; req is dropped before each edge so nothing is accepted.
    for (int i = 0; i < 8; i++) begin
      data_req_i = v[i].req; data_add_i = v[i].add;
      tcdm_gnt_i = v[i].tg; periph_gnt_i = v[i].pg;
      #2;
      chk($sformatf("vec%0d_treq", i), 32'(tcdm_req_o), 32'(v[i].treq));
      chk($sformatf("vec%0d_preq", i), 32'(periph_req_o), 32'(v[i].preq));
      chk($sformatf("vec%0d_gnt", i), 32'(data_gnt_o), 32'(v[i].gnt));
      chk($sformatf("vec%0d_padd", i), periph_add_o, v[i].add);
      chk($sformatf("vec%0d_tadd", i), tcdm_add_o, v[i].add);
      data_req_i = 1'b0; tcdm_gnt_i = 1'b0; periph_gnt_i = 1'b0;
      tick();
    end

    // Single TCDM read.
    data_req_i = 1'b1; data_add_i = TA; data_wen_i = 1'b1; tcdm_gnt_i = 1'b1;
    #2 chk("single_gnt", 32'(data_gnt_o), 1);
    tick();
    data_req_i = 1'b0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b1;
    #2 chk("single_rvalid", 32'(data_r_valid_o), 1);
    chk("single_rdata", data_r_rdata_o, 32'hDEAD_BEEF);
    chk("single_opc", 32'(data_r_opc_o), 0);
    tick();
    tcdm_r_valid_i = 1'b0; data_req_i = 1'b1; data_add_i = PA;
    #2 chk("single_idle_preq", 32'(periph_req_o), 1);
    data_req_i = 1'b0;
    tick();

    // Four back-to-back TCDM reads fill the window.
    data_req_i = 1'b1; data_add_i = TA; tcdm_gnt_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("b2b%0d_gnt", i), 32'(data_gnt_o), 1);
      tick();
    end
    #2 chk("full_gnt", 32'(data_gnt_o), 0);
    chk("full_treq", 32'(tcdm_req_o), 0);
    tcdm_r_valid_i = 1'b1;
    #1 chk("full_rsp_gnt", 32'(data_gnt_o), 0);
    chk("full_rsp_rvalid", 32'(data_r_valid_o), 1);
    tick();
    tcdm_r_valid_i = 1'b0;
    #2 chk("refill_gnt", 32'(data_gnt_o), 1);
    chk("refill_treq", 32'(tcdm_req_o), 1);
    tick();
    data_req_i = 1'b0; tcdm_gnt_i = 1'b0; tcdm_r_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2 chk($sformatf("drain%0d_rvalid", i), 32'(data_r_valid_o), 1);
      tick();
    end
    tcdm_r_valid_i = 1'b0;
    tick();
    chk("drain_spurious", 32'(spurious_rsp_o), 0);

    // TCDM outstanding blocks a periph write until drained.
    data_req_i = 1'b1; data_add_i = TA; tcdm_gnt_i = 1'b1;
    tick();
    tcdm_gnt_i = 1'b0; data_add_i = PA; data_wen_i = 1'b0; periph_gnt_i = 1'b1;
    #2 chk("switch_preq0", 32'(periph_req_o), 0);
    chk("switch_gnt0", 32'(data_gnt_o), 0);
    tick();
    tcdm_r_valid_i = 1'b1;
    #2 chk("switch_preq_rsp", 32'(periph_req_o), 0);
    tick();
    tcdm_r_valid_i = 1'b0;
    #2 chk("switch_preq1", 32'(periph_req_o), 1);
    chk("switch_gnt1", 32'(data_gnt_o), 1);
    tick();
    data_req_i = 1'b0; periph_gnt_i = 1'b0; data_wen_i = 1'b1;
    periph_r_valid_i = 1'b1; periph_r_opc_i = 1'b1;
    #2 chk("periph_rvalid", 32'(data_r_valid_o), 1);
    chk("periph_rdata", data_r_rdata_o, 32'h1234_5678);
    chk("periph_opc", 32'(data_r_opc_o), 1);
    tick();
    periph_r_valid_i = 1'b0; periph_r_opc_i = 1'b0;
    tick();
    chk("pre_spurious", 32'(spurious_rsp_o), 0);

    // Unrequested response at idle.
    tcdm_r_valid_i = 1'b1;
    #2 chk("spur_rvalid", 32'(data_r_valid_o), 0);
    tick();
    tcdm_r_valid_i = 1'b0;
    chk("spur_set", 32'(spurious_rsp_o), 1);
    tick();
    tick();
    chk("spur_sticky", 32'(spurious_rsp_o), 1);

    // Reset mid-stream with a TCDM read outstanding.
    data_req_i = 1'b1; data_add_i = TA; tcdm_gnt_i = 1'b1;
    tick();
    data_req_i = 1'b0; tcdm_gnt_i = 1'b0; rst_ni = 1'b0;
    #2 chk("midrst_spurious", 32'(spurious_rsp_o), 0);
    tick();
    rst_ni = 1'b1; tcdm_r_valid_i = 1'b1;
    #2 chk("postrst_rvalid", 32'(data_r_valid_o), 0);
    tick();
    tcdm_r_valid_i = 1'b0;
    chk("postrst_spurious", 32'(spurious_rsp_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
